// File: rtl/oob_device_responder.sv
// Device-side SATA OOB responder: answers COMRESET with COMINIT and COMWAKE with COMWAKE,
// then trades ALIGN for SYNC and raises linkup once the host has stopped sending ALIGN.
module oob_device_responder #(
    parameter logic [31:0] SEND_TIMEOUT  = 32'h000000A2,
    parameter logic [31:0] WAKE_TIMEOUT  = 32'h000203AD,
    parameter logic [31:0] ALIGN_TIMEOUT = 32'h000203AD,
    parameter int          SYNC_COUNT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        platform_ready,
    input  logic        comm_reset_detect,
    input  logic        comm_wake_detect,
    input  logic        tx_oob_complete,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_is_k,
    input  logic        rx_byte_is_aligned,
    output logic        tx_comm_init,
    output logic        tx_comm_wake,
    output logic [31:0] tx_dout,
    output logic        tx_is_k,
    output logic        tx_set_elec_idle,
    output logic        linkup,
    output logic [3:0]  lax_state
);

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
    localparam logic [3:0]  SYNC_LAST  = 4'(SYNC_COUNT - 1);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        WAIT_NO_RESET = 4'd1,
        SEND_INIT     = 4'd2,
        WAIT_FOR_WAKE = 4'd3,
        WAIT_NO_WAKE  = 4'd4,
        SEND_WAKE     = 4'd5,
        SEND_ALIGN    = 4'd6,
        SEND_SYNC     = 4'd7,
        READY         = 4'd8
    } state_t;

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [3:0]  sync_cnt, sync_cnt_n;
    logic        init_n, wake_n, linkup_n, is_k_n, eidle_n;
    logic [31:0] dout_n;
    logic        eidle_q = 1'b1;
    logic        timeout, align_det;

    assign timeout          = (timer == 32'd0);
    assign align_det        = rx_is_k[0] && (rx_din == PRIM_ALIGN) && rx_byte_is_aligned;
    assign tx_set_elec_idle = eidle_q;
    assign lax_state        = state;

    always_comb begin
        state_n    = state;
        timer_n    = timeout ? 32'd0 : timer - 32'd1;
        sync_cnt_n = sync_cnt;
        init_n     = 1'b0;
        wake_n     = 1'b0;
        linkup_n   = linkup;
        dout_n     = tx_dout;
        is_k_n     = tx_is_k;
        eidle_n    = eidle_q;
        // A host COMRESET anywhere past the init handshake restarts the sequence.
        if (comm_reset_detect && state >= SEND_INIT && state <= READY) begin
            state_n  = WAIT_NO_RESET;
            linkup_n = 1'b0;
            eidle_n  = 1'b1;
            dout_n   = 32'd0;
            is_k_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    eidle_n  = 1'b1;
                    linkup_n = 1'b0;
                    dout_n   = 32'd0;
                    is_k_n   = 1'b0;
                    if (platform_ready && comm_reset_detect) state_n = WAIT_NO_RESET;
                end
                WAIT_NO_RESET: if (!comm_reset_detect) begin
                    init_n  = 1'b1;
                    timer_n = SEND_TIMEOUT;
                    state_n = SEND_INIT;
                end
                SEND_INIT: if (tx_oob_complete || timeout) begin
                    timer_n = WAKE_TIMEOUT;
                    state_n = WAIT_FOR_WAKE;
                end
                WAIT_FOR_WAKE: begin
                    if (comm_wake_detect) state_n = WAIT_NO_WAKE;
                    else if (timeout)     state_n = IDLE;
                end
                WAIT_NO_WAKE: if (!comm_wake_detect) begin
                    wake_n  = 1'b1;
                    timer_n = SEND_TIMEOUT;
                    state_n = SEND_WAKE;
                end
                SEND_WAKE: if (tx_oob_complete || timeout) begin
                    timer_n = ALIGN_TIMEOUT;
                    state_n = SEND_ALIGN;
                end
                SEND_ALIGN: begin
                    eidle_n = 1'b0;
                    dout_n  = PRIM_ALIGN;
                    is_k_n  = 1'b1;
                    if (align_det) begin
                        sync_cnt_n = 4'd0;
                        state_n    = SEND_SYNC;
                    end else if (timeout) begin
                        state_n = IDLE;
                    end
                end
                SEND_SYNC: begin
                    dout_n = PRIM_SYNC;
                    is_k_n = 1'b1;
                    // Any stray ALIGN restarts the run of non-ALIGN words.
                    if (align_det) begin
                        sync_cnt_n = 4'd0;
                    end else begin
                        sync_cnt_n = sync_cnt + 4'd1;
                        if (sync_cnt == SYNC_LAST) state_n = READY;
                    end
                end
                READY: begin
                    linkup_n = 1'b1;
                    dout_n   = PRIM_SYNC;
                    is_k_n   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= 32'd0;
            sync_cnt     <= 4'd0;
            tx_comm_init <= 1'b0;
            tx_comm_wake <= 1'b0;
            linkup       <= 1'b0;
            tx_dout      <= 32'd0;
            tx_is_k      <= 1'b0;
            eidle_q      <= 1'b1;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            sync_cnt     <= sync_cnt_n;
            tx_comm_init <= init_n;
            tx_comm_wake <= wake_n;
            linkup       <= linkup_n;
            tx_dout      <= dout_n;
            tx_is_k      <= is_k_n;
            eidle_q      <= eidle_n;
        end
    end

endmodule

// File: tb/tb_oob_device_responder.sv
// Bench for oob_device_responder: directed vector table for the bring-up corner cases,
// then constrained-random traffic, every cycle compared with a rule-level reference model.
module tb_oob_device_responder;

    localparam logic [31:0] PA      = 32'h7B4A4ABC;
    localparam logic [31:0] PS      = 32'hB5B5957C;
    localparam logic [31:0] D102    = 32'h4A4A4A4A;
    localparam logic [31:0] SEND_T  = 32'd162;
    localparam logic [31:0] WAKE_T  = 32'd100;
    localparam logic [31:0] ALIGN_T = 32'd64;
    localparam int          SC      = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        platform_ready = 1'b0, comm_reset_detect = 1'b0, comm_wake_detect = 1'b0;
    logic        tx_oob_complete = 1'b0, rx_byte_is_aligned = 1'b0;
    logic [31:0] rx_din = 32'd0;
    logic [3:0]  rx_is_k = 4'd0;
    logic        tx_comm_init, tx_comm_wake, tx_is_k, tx_set_elec_idle, linkup;
    logic [31:0] tx_dout;
    logic [3:0]  lax_state;

    int n_chk = 0, n_fail = 0, n_init = 0, n_wake = 0;

    oob_device_responder #(
        .SEND_TIMEOUT(SEND_T), .WAKE_TIMEOUT(WAKE_T), .ALIGN_TIMEOUT(ALIGN_T), .SYNC_COUNT(SC)
    ) dut (
        .clk(clk), .rst(rst), .platform_ready(platform_ready),
        .comm_reset_detect(comm_reset_detect), .comm_wake_detect(comm_wake_detect),
        .tx_oob_complete(tx_oob_complete), .rx_din(rx_din), .rx_is_k(rx_is_k),
        .rx_byte_is_aligned(rx_byte_is_aligned), .tx_comm_init(tx_comm_init),
        .tx_comm_wake(tx_comm_wake), .tx_dout(tx_dout), .tx_is_k(tx_is_k),
        .tx_set_elec_idle(tx_set_elec_idle), .linkup(linkup), .lax_state(lax_state)
    );

    always #5 clk = ~clk;

    // Reference model: the state rules as plain integer bookkeeping, evaluated once per edge.
    int          m_state = 0, m_cnt = 0;
    longint      m_timer = 0;
    bit          m_lu = 0, m_ei = 1, m_isk = 0, m_init = 0, m_wake = 0;
    logic [31:0] m_dout = 32'd0;

    always @(posedge clk) begin : model
        bit     ad, tmo;
        int     ns, nc;
        longint nt;
        ad = rx_is_k[0] && rx_din == PA && rx_byte_is_aligned;
        m_init = 0;
        m_wake = 0;
        if (rst) begin
            m_state = 0; m_timer = 0; m_cnt = 0;
            m_lu = 0; m_ei = 1; m_dout = 32'd0; m_isk = 0;
        end else begin
            tmo = (m_timer == 0);
            nt  = tmo ? 0 : m_timer - 1;
            ns  = m_state;
            nc  = m_cnt;
            if (comm_reset_detect && m_state >= 2 && m_state <= 8) begin
                ns = 1; m_lu = 0; m_ei = 1; m_dout = 32'd0; m_isk = 0;
            end else begin
                case (m_state)
                    0: begin
                        m_ei = 1; m_lu = 0; m_dout = 32'd0; m_isk = 0;
                        if (platform_ready && comm_reset_detect) ns = 1;
                    end
                    1: if (!comm_reset_detect) begin m_init = 1; nt = SEND_T; ns = 2; end
                    2: if (tx_oob_complete || tmo) begin nt = WAKE_T; ns = 3; end
                    3: if (comm_wake_detect) ns = 4; else if (tmo) ns = 0;
                    4: if (!comm_wake_detect) begin m_wake = 1; nt = SEND_T; ns = 5; end
                    5: if (tx_oob_complete || tmo) begin nt = ALIGN_T; ns = 6; end
                    6: begin
                        m_ei = 0; m_dout = PA; m_isk = 1;
                        if (ad) begin nc = 0; ns = 7; end
                        else if (tmo) ns = 0;
                    end
                    7: begin
                        m_dout = PS; m_isk = 1;
                        if (ad) nc = 0;
                        else begin
                            if (nc == SC - 1) ns = 8;
                            nc = (nc + 1) % 16;
                        end
                    end
                    8: begin m_lu = 1; m_dout = PS; m_isk = 1; end
                    default: ns = 0;
                endcase
            end
            m_state = ns; m_timer = nt; m_cnt = nc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model lax_state", 32'(lax_state), 32'(m_state));
        chk("model linkup", 32'(linkup), 32'(m_lu));
        chk("model elec_idle", 32'(tx_set_elec_idle), 32'(m_ei));
        chk("model tx_dout", tx_dout, m_dout);
        chk("model tx_is_k", 32'(tx_is_k), 32'(m_isk));
        chk("model comm_init", 32'(tx_comm_init), 32'(m_init));
        chk("model comm_wake", 32'(tx_comm_wake), 32'(m_wake));
    endtask

    // rx codes: 0 idle word, 1 ALIGN, 2 D10.2, 3 misaligned ALIGN, 4 ALIGN w/o byte-0 K, 5 random
    task automatic drive_rx(input int code);
        rx_byte_is_aligned = 1'b1;
        case (code)
            1: begin rx_din = PA; rx_is_k = 4'b0001; end
            2: begin rx_din = D102; rx_is_k = 4'b0000; end
            3: begin rx_din = PA; rx_is_k = 4'b0001; rx_byte_is_aligned = 1'b0; end
            4: begin rx_din = PA; rx_is_k = 4'b1110; end
            5: begin rx_din = $urandom; rx_is_k = 4'($urandom); end
            default: begin rx_din = 32'd0; rx_is_k = 4'b0000; end
        endcase
    endtask

    typedef struct {
        bit r, pr, crd, cwd, oc;
        int rx, hold;
        int st;
        bit lu, ei;
        int od;
        bit ini, wak;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit pr, bit crd, bit cwd, bit oc, int rx, int hold,
                               int st, bit lu, bit ei, int od, bit ini, bit wak);
        vec_t x;
        x.r = r; x.pr = pr; x.crd = crd; x.cwd = cwd; x.oc = oc; x.rx = rx; x.hold = hold;
        x.st = st; x.lu = lu; x.ei = ei; x.od = od; x.ini = ini; x.wak = wak;
        return x;
    endfunction

    task automatic apply(input vec_t x, input int idx);
        string       nm;
        logic [31:0] exp_dout;
        rst = x.r; platform_ready = x.pr; comm_reset_detect = x.crd;
        comm_wake_detect = x.cwd; tx_oob_complete = x.oc;
        drive_rx(x.rx);
        repeat (x.hold) begin
            @(negedge clk);
            cmp_model();
            if (tx_comm_init) n_init++;
            if (tx_comm_wake) n_wake++;
        end
        exp_dout = (x.od == 1) ? PA : (x.od == 2) ? PS : 32'd0;
        nm = $sformatf("vec%0d", idx);
        chk({nm, " lax_state"}, 32'(lax_state), 32'(x.st));
        chk({nm, " linkup"}, 32'(linkup), 32'(x.lu));
        chk({nm, " elec_idle"}, 32'(tx_set_elec_idle), 32'(x.ei));
        chk({nm, " tx_dout"}, tx_dout, exp_dout);
        chk({nm, " tx_is_k"}, 32'(tx_is_k), 32'(x.od != 0));
        chk({nm, " comm_init"}, 32'(tx_comm_init), 32'(x.ini));
        chk({nm, " comm_wake"}, 32'(tx_comm_wake), 32'(x.wak));
    endtask

    initial begin
        //                 r pr crd cwd oc rx hold   st lu ei od ini wak
        // nominal bring-up
        tbl.push_back(v(1, 1, 0, 0, 0, 0,  2,   0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 20,   1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   2, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 49,   2, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  1,   3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 20,   4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   5, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 10,   5, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  1,   6, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   6, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  1,   7, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  1,   7, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  1,   7, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  4,   8, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   8, 1, 0, 2, 0, 0));
        foreach (tbl[i]) apply(tbl[i], i);
        chk("nominal init pulses", 32'(n_init), 32'd1);
        chk("nominal wake pulses", 32'(n_wake), 32'd1);
        tbl.delete();

        // COMRESET in READY, then interleaved ALIGN during SYNC
        tbl.push_back(v(0, 1, 1, 0, 0, 2,  1,   1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   2, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 2,  1,   3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 2,  2,   4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   5, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 1, 2,  1,   6, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  1,   7, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  3,   7, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  1,   7, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  3,   7, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   8, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   8, 1, 0, 2, 0, 0));
        // no host ALIGN: SEND_ALIGN times out
        tbl.push_back(v(0, 1, 1, 0, 0, 2,  1,   1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   2, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 2,  1,   3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 2,  1,   4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   5, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 1, 2,  1,   6, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2, 64,   6, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2,  1,   0, 0, 1, 0, 0, 0));
        // no wake: WAIT_FOR_WAKE times out 101 cycles after SEND_INIT exits
        tbl.push_back(v(0, 1, 1, 0, 0, 0,  1,   1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   2, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  1,   3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,100,   3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   0, 0, 1, 0, 0, 0));
        // COMRESET ignored without platform_ready; SEND_INIT exits on its own timeout
        tbl.push_back(v(0, 0, 1, 0, 0, 0,  5,   0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0,  1,   1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   2, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,162,   2, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   3, 0, 1, 0, 0, 0));
        // reset in SEND_ALIGN
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1,   4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1,   5, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  1,   6, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  2,   6, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,  1,   0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  3,   0, 0, 1, 0, 0, 0));
        foreach (tbl[i]) apply(tbl[i], 100 + i);

        // random traffic with sticky COMRESET/COMWAKE levels
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            platform_ready = ($urandom_range(0, 19) != 0);
            if (comm_reset_detect) comm_reset_detect = ($urandom_range(0, 3) != 0);
            else                   comm_reset_detect = ($urandom_range(0, 199) == 0);
            if (comm_wake_detect)  comm_wake_detect = ($urandom_range(0, 3) != 0);
            else                   comm_wake_detect = ($urandom_range(0, 19) == 0);
            tx_oob_complete = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 11))
                0, 1:    drive_rx(1);
                2:       drive_rx(3);
                3:       drive_rx(4);
                4:       drive_rx(5);
                5:       drive_rx(0);
                default: drive_rx(2);
            endcase
            @(negedge clk);
            cmp_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
